// File: rtl/cache_arbiter.sv
// Shares one physical memory port between an icache (fills) and a dcache (fills/write-backs).
// Define CACHE_ARBITER_ROUND_ROBIN_EN to alternate tie grants; otherwise the dcache wins ties.
module cache_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  i_pmem_address,
  input  logic         i_pmem_read,
  output logic [255:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  input  logic [31:0]  d_pmem_address,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [255:0] d_pmem_wdata,
  output logic [255:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  output logic [31:0]  mem_address,
  output logic         mem_read,
  output logic         mem_write,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE_I = 2'd1, SERVE_D = 2'd2} state_t;

  state_t       state_reg, state_next;
  logic [31:0]  addr_reg, addr_next;
  logic         read_reg, read_next;
  logic         write_reg, write_next;
  logic [255:0] wdata_reg, wdata_next;
  logic         i_req, d_req, grant_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
  logic last_d_reg;  // set when the dcache held the most recent grant
  assign grant_d = d_req & (~i_req | ~last_d_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d_reg <= 1'b1;
    end else if (state_reg == IDLE && (i_req || d_req)) begin
      last_d_reg <= grant_d;
    end
  end
`else
  assign grant_d = d_req;
`endif

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    read_next  = read_reg;
    write_next = write_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (grant_d) begin
          // A simultaneous read+write from the dcache is treated as a write-back only.
          state_next = SERVE_D;
          addr_next  = d_pmem_address;
          write_next = d_pmem_write;
          read_next  = ~d_pmem_write;
          wdata_next = d_pmem_wdata;
        end else if (i_req) begin
          state_next = SERVE_I;
          addr_next  = i_pmem_address;
          read_next  = 1'b1;
          write_next = 1'b0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          state_next = IDLE;
          read_next  = 1'b0;
          write_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        read_next  = 1'b0;
        write_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= 32'd0;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      wdata_reg <= 256'd0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      read_reg  <= read_next;
      write_reg <= write_next;
      wdata_reg <= wdata_next;
    end
  end

  assign mem_address  = addr_reg;
  assign mem_read     = read_reg;
  assign mem_write    = write_reg;
  assign mem_wdata    = wdata_reg;

  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;
  assign i_pmem_resp  = mem_resp & (state_reg == SERVE_I);
  assign d_pmem_resp  = mem_resp & (state_reg == SERVE_D);
endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized rounds
// compared against a transaction-order model of the arbitration rules.
`timescale 1ns/1ps
module tb_cache_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_pmem_address;
  logic         i_pmem_read;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic [31:0]  d_pmem_address;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_address(d_pmem_address), .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_wdata(d_pmem_wdata), .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // One observed memory transaction, captured at its first and last strobe cycles.
  typedef struct {
    logic [31:0]  addr;
    logic         rd;
    logic         wr;
    logic [255:0] wdata;
    int           dur;
    int           gap;
    bit           stable;
    logic         i_resp;
    logic         d_resp;
    logic [255:0] rdata_i;
    logic [255:0] rdata_d;
  } obs_t;

  typedef struct {
    bit           to_d;
    logic [31:0]  addr;
    bit           wr;
    logic [255:0] wdata;
  } exp_t;

  obs_t         obs_q[$];
  exp_t         exp_q[$];
  int           stray_cnt;
  int           timeout_cnt;
  int           n_cmp = 0;
  int           n_bad = 0;
  bit           model_last_d = 1'b1;
  logic [255:0] salt;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    return {8{a}} ^ salt;
  endfunction

  // Reference: a tie goes to dcache (or to the cache not served last), the loser follows.
  function automatic void model_round(input bit ireq, input bit dreq, input bit dwr,
      input logic [31:0] ia, input logic [31:0] da, input logic [255:0] wd,
      input int d_start, input bit winner_only);
    exp_t ti, td;
    bit   d_first;
    exp_q.delete();
    ti = '{to_d: 1'b0, addr: ia, wr: 1'b0, wdata: '0};
    td = '{to_d: 1'b1, addr: da, wr: dwr, wdata: wd};
    if (ireq && dreq) begin
      if (d_start > 0) d_first = 1'b0;
      else begin
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
        d_first = !model_last_d;
`else
        d_first = 1'b1;
`endif
      end
      exp_q.push_back(d_first ? td : ti);
      if (!winner_only) exp_q.push_back(d_first ? ti : td);
    end else if (ireq) begin
      exp_q.push_back(ti);
    end else if (dreq) begin
      exp_q.push_back(td);
    end
    if (exp_q.size() > 0) model_last_d = exp_q[exp_q.size()-1].to_d;
  endfunction

  // Drives both caches and a memory with fixed latency; records what appears on the memory port.
  task automatic run_round(input bit ireq, input bit drd, input bit dwr, input logic [31:0] ia,
      input logic [31:0] da, input logic [31:0] da2, input int d_start, input int d_chg,
      input logic [255:0] wd, input int lat, input bit winner_only, input bit noise);
    bit   i_done, d_done, strobe, finished;
    int   cnt, gap;
    obs_t cur;
    i_done = !ireq;
    d_done = !(drd || dwr);
    cnt = 0; gap = 0; finished = 1'b0;
    stray_cnt = 0; timeout_cnt = 0;
    obs_q.delete();
    cur = '{default: '0};
    for (int c = 0; c < 200 && !finished; c++) begin
      @(posedge clk); #1;
      i_pmem_read    = !i_done;
      i_pmem_address = ia;
      d_pmem_read    = !d_done && drd && (c >= d_start);
      d_pmem_write   = !d_done && dwr && (c >= d_start);
      d_pmem_address = (c >= d_chg) ? da2 : da;
      d_pmem_wdata   = wd;
      strobe         = mem_read | mem_write;
      mem_resp       = strobe ? (cnt == lat - 1) : (noise && ($urandom_range(3) == 0));
      mem_rdata      = (strobe && mem_resp) ? line_of(mem_address)
                                            : {8{$urandom}};
      @(negedge clk);
      if ((i_pmem_resp || d_pmem_resp) && !(strobe && mem_resp)) stray_cnt++;
      if (strobe) begin
        if (cnt == 0) begin
          cur.addr = mem_address; cur.rd = mem_read; cur.wr = mem_write;
          cur.wdata = mem_wdata; cur.stable = 1'b1; cur.gap = gap;
        end else if (mem_address !== cur.addr || mem_read !== cur.rd ||
                     mem_write !== cur.wr || mem_wdata !== cur.wdata) begin
          cur.stable = 1'b0;
        end
        cnt++;
        if (mem_resp) begin
          cur.dur = cnt; cur.i_resp = i_pmem_resp; cur.d_resp = d_pmem_resp;
          cur.rdata_i = i_pmem_rdata; cur.rdata_d = d_pmem_rdata;
          obs_q.push_back(cur);
          if (i_pmem_resp) i_done = 1'b1;
          if (d_pmem_resp) d_done = 1'b1;
          if (winner_only && (i_pmem_resp || d_pmem_resp)) begin
            i_done = 1'b1; d_done = 1'b1;
          end
          cnt = 0; gap = 0;
        end
      end else begin
        gap++;
      end
      finished = i_done && d_done;
    end
    if (!finished) timeout_cnt++;
    @(posedge clk); #1;
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; mem_resp = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_pmem_read = 1'b1; d_pmem_write = 1'b1; mem_resp = 1'b1;
    d_pmem_address = 32'hDEAD_BEEF; d_pmem_wdata = {8{32'hCAFE_F00D}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({mem_read, mem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b want 0000",
               {mem_read, mem_write, i_pmem_resp, d_pmem_resp});
    end
    n_cmp++;
    if (mem_address !== 32'd0 || mem_wdata !== 256'd0) begin
      n_bad++;
      $display("FAIL reset_regs: got addr %h wdata %h want zeros", mem_address, mem_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0; i_pmem_read = 1'b0; d_pmem_write = 1'b0; mem_resp = 1'b0;
    model_last_d = 1'b1;
  endtask

  task automatic test_icache_read();
    model_round(1, 0, 0, 32'h0000_1040, 32'd0, '0, 0, 0);
    run_round(1, 0, 0, 32'h0000_1040, 32'd0, 32'd0, 0, 1000, '0, 3, 0, 0);
    n_cmp++;
    if (obs_q.size() != 1 || timeout_cnt != 0) begin
      n_bad++;
      $display("FAIL iread_count: got %0d txns (timeouts %0d) want 1", obs_q.size(), timeout_cnt);
    end else begin
      n_cmp++;
      if ({obs_q[0].addr, obs_q[0].rd, obs_q[0].wr} !== {32'h0000_1040, 2'b10}) begin
        n_bad++;
        $display("FAIL iread_cmd: got %h/%b%b want 00001040/10", obs_q[0].addr, obs_q[0].rd, obs_q[0].wr);
      end
      n_cmp++;
      if (obs_q[0].dur != 3) begin
        n_bad++;
        $display("FAIL iread_read_cycles: got %0d want 3", obs_q[0].dur);
      end
      n_cmp++;
      if ({obs_q[0].i_resp, obs_q[0].d_resp} !== 2'b10 || stray_cnt != 0) begin
        n_bad++;
        $display("FAIL iread_resp: got i%b d%b stray %0d want i1 d0 stray 0",
                 obs_q[0].i_resp, obs_q[0].d_resp, stray_cnt);
      end
      n_cmp++;
      if (obs_q[0].rdata_i !== line_of(32'h0000_1040)) begin
        n_bad++;
        $display("FAIL iread_rdata: got %h want %h", obs_q[0].rdata_i, line_of(32'h0000_1040));
      end
    end
  endtask

  task automatic test_dcache_write();
    logic [255:0] b;
    b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    model_round(0, 1, 1, 32'd0, 32'h8000_0020, b, 0, 0);
    run_round(0, 0, 1, 32'd0, 32'h8000_0020, 32'h8000_0020, 0, 1000, b, 4, 0, 0);
    n_cmp++;
    if (obs_q.size() != 1 || timeout_cnt != 0) begin
      n_bad++;
      $display("FAIL dwrite_count: got %0d txns (timeouts %0d) want 1", obs_q.size(), timeout_cnt);
    end else begin
      n_cmp++;
      if ({obs_q[0].addr, obs_q[0].rd, obs_q[0].wr, obs_q[0].stable} !== {32'h8000_0020, 3'b011}) begin
        n_bad++;
        $display("FAIL dwrite_cmd: got %h rd%b wr%b stable%b want 80000020 rd0 wr1 stable1",
                 obs_q[0].addr, obs_q[0].rd, obs_q[0].wr, obs_q[0].stable);
      end
      n_cmp++;
      if (obs_q[0].wdata !== b) begin
        n_bad++;
        $display("FAIL dwrite_wdata: got %h want %h", obs_q[0].wdata, b);
      end
      n_cmp++;
      if ({obs_q[0].i_resp, obs_q[0].d_resp} !== 2'b01 || stray_cnt != 0 || obs_q[0].dur != 4) begin
        n_bad++;
        $display("FAIL dwrite_resp: got i%b d%b stray %0d dur %0d want i0 d1 stray 0 dur 4",
                 obs_q[0].i_resp, obs_q[0].d_resp, stray_cnt, obs_q[0].dur);
      end
    end
  endtask

  task automatic test_tie();
    bit want_d[2];
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
    want_d[0] = 1'b0; want_d[1] = 1'b1;
`else
    want_d[0] = 1'b1; want_d[1] = 1'b1;
`endif
    for (int r = 0; r < 2; r++) begin
      logic [31:0] ia, da;
      ia = 32'h0000_2000 + 32'(r * 64);
      da = 32'h0000_3000 + 32'(r * 64);
      model_round(1, 1, 0, ia, da, '0, 0, 1);
      run_round(1, 1, 0, ia, da, da, 0, 1000, '0, 2, 1, 0);
      n_cmp++;
      if (obs_q.size() != 1 || timeout_cnt != 0) begin
        n_bad++;
        $display("FAIL tie%0d_count: got %0d txns want 1", r, obs_q.size());
      end else if (obs_q[0].d_resp !== want_d[r] || obs_q[0].i_resp !== !want_d[r] ||
                   obs_q[0].addr !== (want_d[r] ? da : ia)) begin
        n_bad++;
        $display("FAIL tie%0d_winner: got d_resp %b addr %h want d_resp %b addr %h", r,
                 obs_q[0].d_resp, obs_q[0].addr, want_d[r], want_d[r] ? da : ia);
      end
    end
  endtask

  task automatic test_reset_mid_serve();
    @(posedge clk); #1;
    d_pmem_write = 1'b1; d_pmem_address = 32'h4000_0100; d_pmem_wdata = {8{32'h1234_5678}};
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (mem_write !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_serving: got mem_write %b want 1", mem_write);
    end
    @(posedge clk); #1;
    rst = 1'b1; d_pmem_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_write !== 1'b0 || mem_address !== 32'd0) begin
      n_bad++;
      $display("FAIL rstmid_abandon: got mem_write %b addr %h want 0 00000000", mem_write, mem_address);
    end
    model_last_d = 1'b1;
    @(posedge clk); #1;
    mem_resp = 1'b1; mem_rdata = {8{32'hFFFF_0000}};
    @(negedge clk);
    n_cmp++;
    if (d_pmem_resp !== 1'b0 || i_pmem_resp !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_late_resp: got d%b i%b want d0 i0", d_pmem_resp, i_pmem_resp);
    end
    @(posedge clk); #1;
    mem_resp = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_idle: got rd%b wr%b want rd0 wr0", mem_read, mem_write);
    end
    model_round(1, 0, 0, 32'h0000_5000, 32'd0, '0, 0, 0);
    run_round(1, 0, 0, 32'h0000_5000, 32'd0, 32'd0, 0, 1000, '0, 2, 0, 0);
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0].gap != 1 || obs_q[0].i_resp !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_next_txn: got %0d txns want 1 icache txn after 1 idle cycle", obs_q.size());
    end
  endtask

  task automatic test_addr_change();
    model_round(1, 1, 0, 32'h0000_6000, 32'h0000_7040, '0, 1, 0);
    run_round(1, 1, 0, 32'h0000_6000, 32'h0000_7000, 32'h0000_7040, 1, 2, '0, 3, 0, 0);
    n_cmp++;
    if (obs_q.size() != 2 || timeout_cnt != 0) begin
      n_bad++;
      $display("FAIL addrchg_count: got %0d txns want 2", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_q[0].addr !== 32'h0000_6000 || !obs_q[0].stable || obs_q[0].i_resp !== 1'b1) begin
        n_bad++;
        $display("FAIL addrchg_hold: got %h stable %b i_resp %b want 00006000 1 1",
                 obs_q[0].addr, obs_q[0].stable, obs_q[0].i_resp);
      end
      n_cmp++;
      if (obs_q[1].addr !== 32'h0000_7040 || obs_q[1].gap != 1 || obs_q[1].d_resp !== 1'b1) begin
        n_bad++;
        $display("FAIL addrchg_dgrant: got %h gap %0d d_resp %b want 00007040 1 1",
                 obs_q[1].addr, obs_q[1].gap, obs_q[1].d_resp);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 40; r++) begin
      bit ireq, drd, dwr, wo;
      int dmode, dst, lat;
      logic [31:0] ia, da;
      logic [255:0] wd;
      ireq = $urandom_range(1);
      dmode = $urandom_range(3);
      if (!ireq && dmode == 0) ireq = 1'b1;
      drd = dmode[0]; dwr = dmode[1];
      dst = (ireq && dmode != 0) ? $urandom_range(1) : 0;
      lat = 1 + $urandom_range(3);
      wo = $urandom_range(1);
      ia = $urandom & 32'hFFFF_FFE0;
      da = $urandom & 32'hFFFF_FFE0;
      wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      model_round(ireq, drd || dwr, dwr, ia, da, wd, dst, wo);
      run_round(ireq, drd, dwr, ia, da, da, dst, 1000, wd, lat, wo, 1);
      n_cmp++;
      if (obs_q.size() != exp_q.size() || timeout_cnt != 0 || stray_cnt != 0) begin
        n_bad++;
        $display("FAIL rnd%0d_count: got %0d txns timeouts %0d stray %0d want %0d 0 0",
                 r, obs_q.size(), timeout_cnt, stray_cnt, exp_q.size());
        continue;
      end
      for (int k = 0; k < exp_q.size(); k++) begin
        n_cmp++;
        if ({obs_q[k].addr, obs_q[k].rd, obs_q[k].wr, obs_q[k].i_resp, obs_q[k].d_resp} !==
            {exp_q[k].addr, !exp_q[k].wr, exp_q[k].wr, !exp_q[k].to_d, exp_q[k].to_d}) begin
          n_bad++;
          $display("FAIL rnd%0d_txn%0d_cmd: got %h rd%b wr%b i%b d%b want %h rd%b wr%b i%b d%b", r, k,
                   obs_q[k].addr, obs_q[k].rd, obs_q[k].wr, obs_q[k].i_resp, obs_q[k].d_resp,
                   exp_q[k].addr, !exp_q[k].wr, exp_q[k].wr, !exp_q[k].to_d, exp_q[k].to_d);
        end
        n_cmp++;
        if (obs_q[k].dur != lat || obs_q[k].gap != 1 || !obs_q[k].stable) begin
          n_bad++;
          $display("FAIL rnd%0d_txn%0d_timing: got dur %0d gap %0d stable %b want %0d 1 1", r, k,
                   obs_q[k].dur, obs_q[k].gap, obs_q[k].stable, lat);
        end
        n_cmp++;
        if ((exp_q[k].to_d ? obs_q[k].rdata_d : obs_q[k].rdata_i) !== line_of(exp_q[k].addr)) begin
          n_bad++;
          $display("FAIL rnd%0d_txn%0d_rdata: got %h want %h", r, k,
                   exp_q[k].to_d ? obs_q[k].rdata_d : obs_q[k].rdata_i, line_of(exp_q[k].addr));
        end
        if (exp_q[k].wr) begin
          n_cmp++;
          if (obs_q[k].wdata !== exp_q[k].wdata) begin
            n_bad++;
            $display("FAIL rnd%0d_txn%0d_wdata: got %h want %h", r, k, obs_q[k].wdata, exp_q[k].wdata);
          end
        end
      end
      $display("round %0d: i=%b drd=%b dwr=%b lat=%0d txns=%0d", r, ireq, drd, dwr, lat, obs_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    i_pmem_address = '0; i_pmem_read = 1'b0;
    d_pmem_address = '0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    salt = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    test_reset();
    test_icache_read();
    test_dcache_write();
    test_tie();
    test_reset_mid_serve();
    test_addr_change();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
